// File: rtl/fifo_drain_pkg.sv
// Shared types and helpers for the FIFO read-side packet drain.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2
  } state_t;

  localparam int PKT_CNT_W = 16;

  // Beat counter width; BEAT_W = $clog2(PKT_LEN) for any legal PKT_LEN (>= 2).
  function automatic int beat_w(input int pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry buffer that absorbs the FIFO read latency; head word is presented combinationally.
module drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is data only; stale contents are never observed because occ gates the head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_pkt_drain.sv
// Pops a synchronous FIFO and frames the words into fixed-length valid/ready packets.
// Optional partial-packet timeout padding is built when FIFO_DRAIN_TIMEOUT_EN is defined.
module fifo_pkt_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PKT_LEN     = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [PKT_CNT_W-1:0]  pkt_count
);

  localparam int BEAT_W = beat_w(PKT_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  if (PKT_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("fifo_pkt_drain: PKT_LEN must be >= 2 and TIMEOUT_CYC >= 1");
  end

  state_t                state;
  logic                  rd_vld_p1;
  logic [1:0]            occ;
  logic [1:0]            credit;
  logic [DATA_WIDTH-1:0] head_data;
  logic [BEAT_W-1:0]     beat;
  logic                  xfer;
  logic                  buf_pop;
  logic                  drained;
  logic                  pad_go;

  drain_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_vld_p1),
    .push_data (fifo_data_out),
    .pop       (buf_pop),
    .occ       (occ),
    .head_data (head_data)
  );

  // Stage p0 -> p1: a pop issued now returns data next cycle, which lands in the buffer.
  assign credit     = occ + {1'b0, rd_vld_p1};
  assign fifo_rd_en = !rst && enable && !fifo_empty && (state != PAD) &&
                      ((credit < 2'd2) || ((credit == 2'd2) && xfer));

  assign m_valid = (state == PAD) || (occ != 2'd0);
  assign m_data  = ((state != PAD) && (occ != 2'd0)) ? head_data : '0;
  assign m_last  = m_valid && (beat == LAST_BEAT);
  assign xfer    = m_valid && m_ready;
  assign buf_pop = xfer && (state != PAD);
  assign drained = !rd_vld_p1 && !fifo_rd_en &&
                   ((occ == 2'd0) || ((occ == 2'd1) && buf_pop));

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TCNT_W-1:0] tcnt;
  logic              idle_wait;

  // Only a stranded partial packet with nothing buffered, in flight or waiting ages.
  assign idle_wait = (beat != '0) && (occ == 2'd0) && !rd_vld_p1 && fifo_empty &&
                     (state != PAD);
  assign pad_go    = (tcnt == TCNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst || !idle_wait) tcnt <= '0;
    else if (!pad_go)      tcnt <= tcnt + 1'b1;
  end
`else
  assign pad_go = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_vld_p1 <= 1'b0;
      beat      <= '0;
      pkt_count <= '0;
    end else begin
      rd_vld_p1 <= fifo_rd_en;
      if (xfer) begin
        if (m_last) begin
          beat      <= '0;
          pkt_count <= pkt_count + 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (fifo_rd_en)  state <= STREAM;
          else if (pad_go) state <= PAD;
        end
        STREAM: begin
          if (pad_go)       state <= PAD;
          else if (drained) state <= IDLE;
        end
        PAD: begin
          if (xfer && m_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Directed bench for fifo_pkt_drain with a behavioural synchronous FIFO on the read side.
module tb_fifo_pkt_drain;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_last;
  logic [DW-1:0] fifo_data_out;
  logic [DW-1:0] m_data;
  logic [15:0]   pkt_count;

  logic [DW-1:0] fmem [0:1023];
  int            rd_idx = 0;
  int            wr_idx = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          e_rd;
    logic          e_vld;
    logic          e_last;
    logic [DW-1:0] e_data;
  } vec_t;
  vec_t tv [6];

  fifo_pkt_drain dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  // Synchronous FIFO model: data appears the cycle after the pop.
  assign fifo_empty = (rd_idx == wr_idx);
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= fmem[rd_idx];
      rd_idx        <= rd_idx + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wr_idx] = base + 8'(i);
      wr_idx++;
    end
  endtask

  task automatic cyc(input logic en, input logic rdy);
    @(negedge clk);
    enable  = en;
    m_ready = rdy;
    #1;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    #1;
    if (chk) begin
      check("rst_valid", m_valid, 1'b0);
      check("rst_last", m_last, 1'b0);
      check("rst_data", m_data, 8'h00);
      check("rst_pkt", pkt_count, 16'd0);
      check("rst_rd_en", fifo_rd_en, 1'b0);
    end
    wr_idx = rd_idx;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives enable/m_ready, checks order, framing, stall stability and pop credit.
  task automatic run_stream(input string tag, input int n, input logic [7:0] base,
                            input int max_cyc, input bit tog, input int off_lo, input int off_hi);
    int            got = 0;
    int            outst = 0;
    int            c = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    bit            en;
    bit            rdy;
    bit            xf;
    while (got < n && c < max_cyc) begin
      en  = !(c >= off_lo && c < off_hi);
      rdy = tog ? (c % 2 == 0) : 1'b1;
      cyc(en, rdy);
      xf = m_valid && m_ready;
      if (prev_stall) begin
        check({tag, "_stall_valid"}, m_valid, 1'b1);
        check({tag, "_stall_data"}, m_data, prev_data);
        check({tag, "_stall_last"}, m_last, prev_last);
      end
      if (fifo_rd_en) check({tag, "_credit"}, (outst < 2) || (outst == 2 && xf), 1'b1);
      if (!en) check({tag, "_no_pop"}, fifo_rd_en, 1'b0);
      if (xf) begin
        check({tag, "_data"}, m_data, base + 8'(got));
        check({tag, "_last"}, m_last, (got % 16) == 15);
        got++;
      end
      outst = outst + int'(fifo_rd_en) - int'(xf);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      c++;
    end
    check({tag, "_done"}, got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int nx;
    int first_pad;

    tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    tv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset with words waiting in the FIFO, then 32 back-to-back beats.
    push_words(4, 8'hEE);
    do_reset(1'b1);
    push_words(32, 8'h00);
    for (int c = 0; c < 36; c++) begin
      cyc(1'b1, 1'b1);
      check("t1_rd_en", fifo_rd_en, c < 32);
      check("t1_valid", m_valid, (c >= 2 && c < 34));
      if (c >= 2 && c < 34) begin
        check("t1_data", m_data, c - 2);
        check("t1_last", m_last, ((c - 2) % 16) == 15);
      end
    end
    check("t1_pkt", pkt_count, 16'd2);

    // Consumer toggling ready every cycle.
    do_reset(1'b0);
    push_words(16, 8'h40);
    run_stream("t2", 16, 8'h40, 100, 1'b1, -1, -1);
    cyc(1'b0, 1'b1);
    check("t2_pkt", pkt_count, 16'd1);

    // Single word, including a one-cycle stall.
    do_reset(1'b0);
    push_words(1, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      cyc(tv[i].en, tv[i].rdy);
      check("t3_rd_en", fifo_rd_en, tv[i].e_rd);
      check("t3_valid", m_valid, tv[i].e_vld);
      if (tv[i].e_vld) begin
        check("t3_data", m_data, tv[i].e_data);
        check("t3_last", m_last, tv[i].e_last);
      end
    end

    // Enable dropped while beat 5 is presented; packet still closes on beat 15.
    do_reset(1'b0);
    push_words(16, 8'h80);
    run_stream("t4", 16, 8'h80, 100, 1'b0, 7, 13);
    cyc(1'b0, 1'b1);
    check("t4_pkt", pkt_count, 16'd1);

    // Reset with two words buffered at beat 9.
    do_reset(1'b0);
    push_words(16, 8'hC0);
    for (int c = 0; c < 12; c++) cyc(1'b1, c < 11);
    cyc(1'b1, 1'b0);
    check("t5_pre_valid", m_valid, 1'b1);
    check("t5_pre_data", m_data, 8'hC9);
    check("t5_pre_rd_en", fifo_rd_en, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    check("t5_rst_valid", m_valid, 1'b0);
    check("t5_rst_last", m_last, 1'b0);
    check("t5_rst_data", m_data, 8'h00);
    check("t5_rst_pkt", pkt_count, 16'd0);
    check("t5_rst_rd_en", fifo_rd_en, 1'b0);
    wr_idx = rd_idx;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_words(16, 8'hD0);
    run_stream("t5", 16, 8'hD0, 60, 1'b0, -1, -1);
    cyc(1'b0, 1'b1);
    check("t5_pkt", pkt_count, 16'd1);

    // Partial packet of three words followed by a long idle stretch.
    do_reset(1'b0);
    push_words(3, 8'h31);
    nv = 0; nx = 0; first_pad = -1;
    for (int c = 0; c < 120; c++) begin
      cyc(1'b1, 1'b1);
      if (m_valid) nv++;
      if (m_valid && m_ready) begin
        if (nx < 3) begin
          check("t6_data", m_data, 8'h31 + 8'(nx));
        end else begin
          if (first_pad < 0) first_pad = c;
          check("t6_pad_data", m_data, 8'h00);
          check("t6_pad_last", m_last, nx == 15);
        end
        nx++;
      end
    end
`ifdef FIFO_DRAIN_TIMEOUT_EN
    check("t6_beats", nx, 16);
    check("t6_pkt", pkt_count, 16'd1);
    check("t6_pad_delay", (first_pad >= 68 && first_pad <= 75), 1'b1);
`else
    check("t6_valid_cycles", nv, 3);
    check("t6_beats", nx, 3);
    check("t6_pkt", pkt_count, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
